// File: rtl/rvm_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rvm_mem_arbiter_pkg
// Purpose  : Shared encodings for the memory-port arbiter: FSM states,
//            access-size codes, requester identifiers and the alignment rule.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package rvm_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    localparam logic [1:0] RVM_MEM_BYTE    = 2'b00;
    localparam logic [1:0] RVM_MEM_HALF    = 2'b01;
    localparam logic [1:0] RVM_MEM_WORD    = 2'b10;
    localparam logic [1:0] RVM_MEM_ILLEGAL = 2'b11;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

    // Fetches are presented as word accesses, so one rule covers both sides.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            RVM_MEM_BYTE: bad = 1'b0;
            RVM_MEM_HALF: bad = off[0];
            RVM_MEM_WORD: bad = (off != 2'b00);
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvm_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rvm_mem_arbiter_if
// Purpose  : Bundles the fetch, load/store and external memory signals of the
//            arbiter. The slave modport is the arbiter's view; the master
//            modport is the view of the surrounding core and memory.
// Ports    : ifu_* fetch channel, lsu_* data channel, mem_* memory pins, busy
// Revision : 1.0  initial release
// ============================================================================
interface rvm_mem_arbiter_if;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rdata;
    logic        ifu_error;
    logic        ifu_misalign;

    logic        lsu_req;
    logic        lsu_wen;
    logic [1:0]  lsu_size;
    logic        lsu_signed;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_gnt;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_error;
    logic        lsu_misalign;

    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        mem_c_en;
    logic [3:0]  mem_b_en;
    logic        mem_error;
    logic        mem_stall;

    logic        busy;

    modport slave (
        input  ifu_req, ifu_addr,
        output ifu_gnt, ifu_rsp_valid, ifu_rdata, ifu_error, ifu_misalign,
        input  lsu_req, lsu_wen, lsu_size, lsu_signed, lsu_addr, lsu_wdata,
        output lsu_gnt, lsu_rsp_valid, lsu_rdata, lsu_error, lsu_misalign,
        output mem_addr, mem_wdata, mem_c_en, mem_b_en,
        input  mem_rdata, mem_error, mem_stall,
        output busy
    );

    modport master (
        output ifu_req, ifu_addr,
        input  ifu_gnt, ifu_rsp_valid, ifu_rdata, ifu_error, ifu_misalign,
        output lsu_req, lsu_wen, lsu_size, lsu_signed, lsu_addr, lsu_wdata,
        input  lsu_gnt, lsu_rsp_valid, lsu_rdata, lsu_error, lsu_misalign,
        input  mem_addr, mem_wdata, mem_c_en, mem_b_en,
        output mem_rdata, mem_error, mem_stall,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/rvm_mem_lanes.sv
`default_nettype none
// ============================================================================
// Module   : rvm_mem_lanes
// Purpose  : Purely combinational byte-lane logic. Request side: misalign
//            check, byte-strobe generation and store-data replication.
//            Response side: load byte/half extraction with sign/zero extend.
// Ports    : req_off/req_size/req_wen/req_wdata -> req_b_en, req_wdata_lanes,
//            req_misalign; rsp_off/rsp_size/rsp_signed/mem_rdata -> load_data
// Revision : 1.0  initial release
// ============================================================================
module rvm_mem_lanes
    import rvm_mem_arbiter_pkg::*;
(
    input  logic [1:0]  req_off,
    input  logic [1:0]  req_size,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    output logic [3:0]  req_b_en,
    output logic [31:0] req_wdata_lanes,
    output logic        req_misalign,
    input  logic [1:0]  rsp_off,
    input  logic [1:0]  rsp_size,
    input  logic        rsp_signed,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        req_misalign    = is_misaligned(req_size, req_off);
        req_b_en        = 4'b0000;
        req_wdata_lanes = req_wdata;
        case (req_size)
            RVM_MEM_BYTE: begin
                req_wdata_lanes = {4{req_wdata[7:0]}};
                if (req_wen) req_b_en = 4'b0001 << req_off;
            end
            RVM_MEM_HALF: begin
                req_wdata_lanes = {2{req_wdata[15:0]}};
                if (req_wen) req_b_en = req_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                if (req_wen) req_b_en = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_byte = mem_rdata[{rsp_off, 3'b000} +: 8];
        w_half = mem_rdata[{rsp_off[1], 4'b0000} +: 16];
        case (rsp_size)
            RVM_MEM_BYTE: load_data = {{24{rsp_signed & w_byte[7]}}, w_byte};
            RVM_MEM_HALF: load_data = {{16{rsp_signed & w_half[15]}}, w_half};
            default:      load_data = mem_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rvm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rvm_mem_arbiter
// Purpose  : Shares one memory port between the fetch unit and the load/store
//            unit. Round-robin on ties, IDLE -> ACCESS -> RESP sequencing,
//            misaligned accesses answered without touching memory, and a
//            stall timeout that aborts the access with an error.
// Ports    : clk, resetn (async, active-low), bus (rvm_mem_arbiter_if.slave)
// Params   : TIMEOUT_CYCLES - stalled ACCESS edges before abort, 0 = never
// Revision : 1.0  initial release
// ============================================================================
module rvm_mem_arbiter
    import rvm_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                resetn,
    rvm_mem_arbiter_if.slave    bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

    state_t           r_state;
    req_id_t          r_last_gnt;
    req_id_t          r_owner;
    logic [1:0]       r_off;
    logic [1:0]       r_size;
    logic             r_signed;
    logic             r_wen;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_b_en;
    logic             r_mem_c_en;
    logic             r_ifu_rsp_valid, r_ifu_error, r_ifu_misalign;
    logic [31:0]      r_ifu_rdata;
    logic             r_lsu_rsp_valid, r_lsu_error, r_lsu_misalign;
    logic [31:0]      r_lsu_rdata;

    logic             w_grant_ifu, w_grant_lsu, w_any;
    req_id_t          w_sel;
    logic [31:0]      w_req_addr;
    logic [1:0]       w_req_size;
    logic             w_req_wen;
    logic [3:0]       w_req_b_en;
    logic [31:0]      w_req_wdata;
    logic             w_req_mis;
    logic [31:0]      w_load_data;
    logic [CNT_W-1:0] w_cnt_next;
    state_t           w_next_state;
    logic             w_rsp_fire;
    req_id_t          w_rsp_owner;
    logic [31:0]      w_rsp_rdata;
    logic             w_rsp_error, w_rsp_mis;

    // Ties go to whichever side was not granted last time.
    assign w_grant_ifu = (r_state == ST_IDLE) && bus.ifu_req
                         && (!bus.lsu_req || (r_last_gnt == REQ_LSU));
    assign w_grant_lsu = (r_state == ST_IDLE) && bus.lsu_req
                         && (!bus.ifu_req || (r_last_gnt == REQ_IFU));
    assign w_any       = w_grant_ifu | w_grant_lsu;
    assign w_sel       = w_grant_lsu ? REQ_LSU : REQ_IFU;
    assign w_req_addr  = w_grant_lsu ? bus.lsu_addr : bus.ifu_addr;
    assign w_req_size  = w_grant_lsu ? bus.lsu_size : RVM_MEM_WORD;
    assign w_req_wen   = w_grant_lsu & bus.lsu_wen;
    assign w_cnt_next  = r_cnt + 1'b1;

    rvm_mem_lanes u_lanes (
        .req_off         (w_req_addr[1:0]),
        .req_size        (w_req_size),
        .req_wen         (w_req_wen),
        .req_wdata       (bus.lsu_wdata),
        .req_b_en        (w_req_b_en),
        .req_wdata_lanes (w_req_wdata),
        .req_misalign    (w_req_mis),
        .rsp_off         (r_off),
        .rsp_size        (r_size),
        .rsp_signed      (r_signed),
        .mem_rdata       (bus.mem_rdata),
        .load_data       (w_load_data)
    );

    always_comb begin
        w_next_state = r_state;
        w_rsp_fire   = 1'b0;
        w_rsp_owner  = r_owner;
        w_rsp_rdata  = 32'h0;
        w_rsp_error  = 1'b0;
        w_rsp_mis    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    if (w_req_mis) begin
                        w_next_state = ST_RESP;
                        w_rsp_fire   = 1'b1;
                        w_rsp_owner  = w_sel;
                        w_rsp_error  = 1'b1;
                        w_rsp_mis    = 1'b1;
                    end else begin
                        w_next_state = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (!bus.mem_stall) begin
                    w_next_state = ST_RESP;
                    w_rsp_fire   = 1'b1;
                    w_rsp_error  = bus.mem_error;
                    w_rsp_rdata  = (bus.mem_error || r_wen) ? 32'h0 : w_load_data;
                end else if ((TIMEOUT_CYCLES != 0) && (w_cnt_next == CNT_LIM)) begin
                    w_next_state = ST_RESP;
                    w_rsp_fire   = 1'b1;
                    w_rsp_error  = 1'b1;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= ST_IDLE;
            r_last_gnt      <= REQ_LSU;
            r_owner         <= REQ_IFU;
            r_off           <= 2'b00;
            r_size          <= RVM_MEM_WORD;
            r_signed        <= 1'b0;
            r_wen           <= 1'b0;
            r_cnt           <= '0;
            r_mem_addr      <= 32'h0;
            r_mem_wdata     <= 32'h0;
            r_mem_b_en      <= 4'b0000;
            r_mem_c_en      <= 1'b0;
            r_ifu_rsp_valid <= 1'b0;
            r_ifu_rdata     <= 32'h0;
            r_ifu_error     <= 1'b0;
            r_ifu_misalign  <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;
            r_lsu_rdata     <= 32'h0;
            r_lsu_error     <= 1'b0;
            r_lsu_misalign  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // Response registers are live only during RESP, zero otherwise.
            r_ifu_rsp_valid <= w_rsp_fire && (w_rsp_owner == REQ_IFU);
            r_ifu_rdata     <= (w_rsp_fire && (w_rsp_owner == REQ_IFU)) ? w_rsp_rdata : 32'h0;
            r_ifu_error     <= w_rsp_fire && (w_rsp_owner == REQ_IFU) && w_rsp_error;
            r_ifu_misalign  <= w_rsp_fire && (w_rsp_owner == REQ_IFU) && w_rsp_mis;
            r_lsu_rsp_valid <= w_rsp_fire && (w_rsp_owner == REQ_LSU);
            r_lsu_rdata     <= (w_rsp_fire && (w_rsp_owner == REQ_LSU)) ? w_rsp_rdata : 32'h0;
            r_lsu_error     <= w_rsp_fire && (w_rsp_owner == REQ_LSU) && w_rsp_error;
            r_lsu_misalign  <= w_rsp_fire && (w_rsp_owner == REQ_LSU) && w_rsp_mis;

            if ((r_state == ST_IDLE) && w_any) begin
                r_last_gnt <= w_sel;
                r_owner    <= w_sel;
                r_off      <= w_req_addr[1:0];
                r_size     <= w_req_size;
                r_signed   <= w_grant_lsu & bus.lsu_signed;
                r_wen      <= w_req_wen;
                // Memory pins keep their previous address/data when a
                // misaligned request short-circuits to RESP.
                if (!w_req_mis) begin
                    r_mem_addr  <= {w_req_addr[31:2], 2'b00};
                    r_mem_wdata <= w_req_wdata;
                    r_mem_b_en  <= w_req_b_en;
                    r_mem_c_en  <= 1'b1;
                    r_cnt       <= '0;
                end
            end

            if (r_state == ST_ACCESS) begin
                if (bus.mem_stall) r_cnt <= w_cnt_next;
                if (w_next_state != ST_ACCESS) begin
                    r_mem_c_en <= 1'b0;
                    r_mem_b_en <= 4'b0000;
                end
            end
        end
    end

    assign bus.ifu_gnt       = w_grant_ifu;
    assign bus.ifu_rsp_valid = r_ifu_rsp_valid;
    assign bus.ifu_rdata     = r_ifu_rdata;
    assign bus.ifu_error     = r_ifu_error;
    assign bus.ifu_misalign  = r_ifu_misalign;
    assign bus.lsu_gnt       = w_grant_lsu;
    assign bus.lsu_rsp_valid = r_lsu_rsp_valid;
    assign bus.lsu_rdata     = r_lsu_rdata;
    assign bus.lsu_error     = r_lsu_error;
    assign bus.lsu_misalign  = r_lsu_misalign;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.mem_b_en      = r_mem_b_en;
    assign bus.mem_c_en      = r_mem_c_en;
    assign bus.busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rvm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvm_mem_arbiter
// Purpose  : Self-checking bench for rvm_mem_arbiter (TIMEOUT_CYCLES = 4):
//            reset values, directed vector table, tie alternation, reset
//            during ACCESS, and random transactions against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rvm_mem_arbiter;
    import rvm_mem_arbiter_pkg::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    rvm_mem_arbiter_if bus ();

    rvm_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        is_lsu;
        logic        wen;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          stalls;
        logic        merr;
    } txn_in_t;

    typedef struct {
        int          rsp_cyc;
        int          cen_cnt;
        logic [3:0]  ben;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        mis;
    } txn_exp_t;

    typedef struct {
        int          gnt_cyc;
        int          rsp_cyc;
        int          cen_cnt;
        logic [31:0] maddr;
        logic [3:0]  ben;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        int          stray;
    } txn_obs_t;

    typedef struct {
        txn_in_t  in;
        txn_exp_t exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic txn_in_t mk_in(input logic is_lsu, input logic wen, input logic [1:0] size,
                                      input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [31:0] mrdata, input int stalls, input logic merr);
        txn_in_t v;
        v.is_lsu = is_lsu; v.wen = wen; v.size = size; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.mrdata = mrdata; v.stalls = stalls; v.merr = merr;
        return v;
    endfunction

    function automatic txn_exp_t mk_exp(input int rsp_cyc, input int cen_cnt, input logic [3:0] ben,
                                        input logic [31:0] wdata, input logic [31:0] rdata,
                                        input logic err, input logic mis);
        txn_exp_t e;
        e.rsp_cyc = rsp_cyc; e.cen_cnt = cen_cnt; e.ben = ben; e.wdata = wdata;
        e.rdata = rdata; e.err = err; e.mis = mis;
        return e;
    endfunction

    // Reference model: derives the whole transaction outcome from the access
    // rules with plain arithmetic (shifts, masks, multiplies).
    function automatic txn_exp_t exp_of(input txn_in_t v);
        txn_exp_t    e;
        int          sz;
        int          off;
        logic        bad;
        logic [31:0] val;
        sz  = v.is_lsu ? int'(v.size) : 2;
        off = int'(v.addr & 32'd3);
        bad = (sz == 3) || (sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0);
        e = mk_exp(0, 0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        if (v.is_lsu && v.wen) begin
            if (sz == 0) begin
                e.ben   = 4'(1 << off);
                e.wdata = (v.wdata & 32'hFF) * 32'h0101_0101;
            end else if (sz == 1) begin
                e.ben   = 4'(3 << ((off / 2) * 2));
                e.wdata = (v.wdata & 32'hFFFF) * 32'h0001_0001;
            end else begin
                e.ben   = 4'hF;
                e.wdata = v.wdata;
            end
        end
        if (bad) begin
            e.rsp_cyc = 1; e.cen_cnt = 0; e.err = 1'b1; e.mis = 1'b1;
        end else if (v.stalls >= TO) begin
            e.rsp_cyc = TO + 1; e.cen_cnt = TO; e.err = 1'b1;
        end else begin
            e.rsp_cyc = v.stalls + 2;
            e.cen_cnt = v.stalls + 1;
            e.err     = v.merr;
            if (!v.merr && !(v.is_lsu && v.wen)) begin
                if (sz == 0) begin
                    val = (v.mrdata >> (8 * off)) & 32'hFF;
                    if (v.sgn && val >= 32'h80) val = val | 32'hFFFF_FF00;
                end else if (sz == 1) begin
                    val = (v.mrdata >> (16 * (off / 2))) & 32'hFFFF;
                    if (v.sgn && val >= 32'h8000) val = val | 32'hFFFF_0000;
                end else begin
                    val = v.mrdata;
                end
                e.rdata = val;
            end
        end
        return e;
    endfunction

    task automatic clear_reqs();
        bus.ifu_req = 1'b0;
        bus.lsu_req = 1'b0;
    endtask

    // One transaction from a single requester; mem_stall is held high for the
    // first v.stalls ACCESS cycles. Cycle 0 is the cycle the request appears.
    task automatic run_txn(input txn_in_t v, output txn_obs_t o);
        logic granted;
        logic done;
        int   n_cen;
        o.gnt_cyc = -1; o.rsp_cyc = -1; o.cen_cnt = 0; o.maddr = 32'h0; o.ben = 4'h0;
        o.wdata = 32'h0; o.rdata = 32'h0; o.err = 1'b0; o.mis = 1'b0; o.stray = 0;
        granted = 1'b0; done = 1'b0; n_cen = 0;
        @(posedge clk); #1;
        bus.mem_rdata = v.mrdata;
        bus.mem_error = v.merr;
        bus.mem_stall = 1'b0;
        if (v.is_lsu) begin
            bus.lsu_req = 1'b1; bus.lsu_wen = v.wen; bus.lsu_size = v.size;
            bus.lsu_signed = v.sgn; bus.lsu_addr = v.addr; bus.lsu_wdata = v.wdata;
        end else begin
            bus.ifu_req = 1'b1; bus.ifu_addr = v.addr;
        end
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (v.is_lsu ? bus.lsu_gnt : bus.ifu_gnt) begin
                if (o.gnt_cyc < 0) o.gnt_cyc = c;
                granted = 1'b1;
            end
            if (v.is_lsu ? bus.ifu_gnt : bus.lsu_gnt) o.stray++;
            if (bus.mem_c_en) begin
                if (n_cen == 0) begin
                    o.maddr = bus.mem_addr; o.ben = bus.mem_b_en; o.wdata = bus.mem_wdata;
                end
                bus.mem_stall = (n_cen < v.stalls);
                n_cen++;
            end else if (bus.mem_b_en != 4'h0) begin
                o.stray++;
            end
            if (v.is_lsu ? bus.ifu_rsp_valid : bus.lsu_rsp_valid) o.stray++;
            if (v.is_lsu ? bus.lsu_rsp_valid : bus.ifu_rsp_valid) begin
                o.rsp_cyc = c;
                o.rdata = v.is_lsu ? bus.lsu_rdata : bus.ifu_rdata;
                o.err   = v.is_lsu ? bus.lsu_error : bus.ifu_error;
                o.mis   = v.is_lsu ? bus.lsu_misalign : bus.ifu_misalign;
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (granted) clear_reqs();
        end
        o.cen_cnt = n_cen;
        bus.mem_stall = 1'b0;
        clear_reqs();
    endtask

    task automatic compare(input string tag, input txn_in_t v, input txn_exp_t e, input txn_obs_t o);
        chk({tag, ".gnt_cyc"}, 32'(o.gnt_cyc), 32'd0);
        chk({tag, ".rsp_cyc"}, 32'(o.rsp_cyc), 32'(e.rsp_cyc));
        chk({tag, ".c_en_cycles"}, 32'(o.cen_cnt), 32'(e.cen_cnt));
        if (e.cen_cnt > 0) begin
            chk({tag, ".mem_addr"}, o.maddr, v.addr & ~32'h3);
            chk({tag, ".b_en"}, 32'(o.ben), 32'(e.ben));
            if (v.is_lsu && v.wen) chk({tag, ".mem_wdata"}, o.wdata, e.wdata);
        end
        chk({tag, ".rdata"}, o.rdata, e.rdata);
        chk({tag, ".error"}, 32'(o.err), 32'(e.err));
        chk({tag, ".misalign"}, 32'(o.mis), 32'(e.mis));
        chk({tag, ".stray"}, 32'(o.stray), 32'd0);
    endtask

    vec_t tbl[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_obs_t obs;
        txn_in_t  v;
        int       order[$];
        int       seen_cen;
        int       rsp_cnt;
        logic     granted;

        bus.ifu_req = 0; bus.ifu_addr = 0;
        bus.lsu_req = 0; bus.lsu_wen = 0; bus.lsu_size = 0; bus.lsu_signed = 0;
        bus.lsu_addr = 0; bus.lsu_wdata = 0;
        bus.mem_rdata = 0; bus.mem_error = 0; bus.mem_stall = 0;

        // ---------------- directed vector table ----------------
        //               lsu wen size sgn addr          wdata         mrdata       stl err
        tbl[0].in  = mk_in(0, 0, 2'd2, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0);
        tbl[0].exp = mk_exp(2, 1, 4'h0, 32'h0,        32'hDEADBEEF, 0, 0);
        tbl[1].in  = mk_in(1, 0, 2'd0, 1, 32'h203, 32'h0,        32'h80112233, 0, 0);
        tbl[1].exp = mk_exp(2, 1, 4'h0, 32'h0,        32'hFFFFFF80, 0, 0);
        tbl[2].in  = mk_in(1, 0, 2'd0, 0, 32'h203, 32'h0,        32'h80112233, 0, 0);
        tbl[2].exp = mk_exp(2, 1, 4'h0, 32'h0,        32'h00000080, 0, 0);
        tbl[3].in  = mk_in(1, 1, 2'd1, 0, 32'h402, 32'h0000ABCD, 32'h55555555, 0, 0);
        tbl[3].exp = mk_exp(2, 1, 4'hC, 32'hABCDABCD, 32'h0,        0, 0);
        tbl[4].in  = mk_in(1, 0, 2'd2, 0, 32'h006, 32'h0,        32'h12345678, 0, 0);
        tbl[4].exp = mk_exp(1, 0, 4'h0, 32'h0,        32'h0,        1, 1);
        tbl[5].in  = mk_in(0, 0, 2'd2, 0, 32'h102, 32'h0,        32'h12345678, 0, 0);
        tbl[5].exp = mk_exp(1, 0, 4'h0, 32'h0,        32'h0,        1, 1);
        tbl[6].in  = mk_in(1, 0, 2'd3, 0, 32'h000, 32'h0,        32'h12345678, 0, 0);
        tbl[6].exp = mk_exp(1, 0, 4'h0, 32'h0,        32'h0,        1, 1);
        tbl[7].in  = mk_in(1, 0, 2'd1, 1, 32'h001, 32'h0,        32'h12345678, 0, 0);
        tbl[7].exp = mk_exp(1, 0, 4'h0, 32'h0,        32'h0,        1, 1);
        tbl[8].in  = mk_in(1, 0, 2'd1, 1, 32'h006, 32'h0,        32'h9ABC1234, 0, 0);
        tbl[8].exp = mk_exp(2, 1, 4'h0, 32'h0,        32'hFFFF9ABC, 0, 0);
        tbl[9].in  = mk_in(1, 1, 2'd0, 0, 32'h011, 32'h123456EF, 32'h0,        0, 0);
        tbl[9].exp = mk_exp(2, 1, 4'h2, 32'hEFEFEFEF, 32'h0,        0, 0);
        tbl[10].in = mk_in(1, 1, 2'd2, 0, 32'h020, 32'hCAFEF00D, 32'h0,        0, 0);
        tbl[10].exp= mk_exp(2, 1, 4'hF, 32'hCAFEF00D, 32'h0,        0, 0);
        tbl[11].in = mk_in(1, 0, 2'd2, 0, 32'h030, 32'h0,        32'h11111111, 10, 0);
        tbl[11].exp= mk_exp(5, 4, 4'h0, 32'h0,        32'h0,        1, 0);
        tbl[12].in = mk_in(0, 0, 2'd2, 0, 32'h040, 32'h0,        32'h12345678, 2, 1);
        tbl[12].exp= mk_exp(4, 3, 4'h0, 32'h0,        32'h0,        1, 0);
        tbl[13].in = mk_in(1, 0, 2'd0, 0, 32'h041, 32'h0,        32'h0000FF00, 3, 0);
        tbl[13].exp= mk_exp(5, 4, 4'h0, 32'h0,        32'h000000FF, 0, 0);
        tbl[14].in = mk_in(1, 1, 2'd1, 0, 32'h000, 32'hFFFF1234, 32'hAAAAAAAA, 3, 0);
        tbl[14].exp= mk_exp(5, 4, 4'h3, 32'h12341234, 32'h0,        0, 0);

        // ---------------- reset state ----------------
        #12;
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.mem_c_en", 32'(bus.mem_c_en), 32'd0);
        chk("reset.mem_b_en", 32'(bus.mem_b_en), 32'd0);
        chk("reset.mem_addr", bus.mem_addr, 32'h0);
        chk("reset.mem_wdata", bus.mem_wdata, 32'h0);
        chk("reset.rsp_valid", 32'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 32'd0);
        chk("reset.rdata", bus.ifu_rdata | bus.lsu_rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // ---------------- tie right after reset, then alternation ----------------
        @(posedge clk); #1;
        bus.ifu_req = 1; bus.ifu_addr = 32'h80;
        bus.lsu_req = 1; bus.lsu_wen = 0; bus.lsu_size = RVM_MEM_WORD; bus.lsu_addr = 32'h84;
        bus.mem_rdata = 32'h0; bus.mem_stall = 0; bus.mem_error = 0;
        rsp_cnt = 0;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            if (bus.ifu_gnt && bus.lsu_gnt) rsp_cnt++;
            if (bus.ifu_gnt) order.push_back(0);
            if (bus.lsu_gnt) order.push_back(1);
            @(posedge clk); #1;
        end
        clear_reqs();
        chk("tie.grant_count", 32'(order.size()), 32'd4);
        chk("tie.double_grant", 32'(rsp_cnt), 32'd0);
        for (int i = 0; i < order.size(); i++)
            chk($sformatf("tie.grant%0d_is_lsu", i), 32'(order[i]), 32'(i % 2));
        repeat (4) @(posedge clk);
        #1;
        chk("tie.idle_after", 32'(bus.busy), 32'd0);

        // ---------------- directed table ----------------
        for (int i = 0; i < 15; i++) begin
            run_txn(tbl[i].in, obs);
            compare($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp, obs);
        end

        // ---------------- reset during ACCESS ----------------
        @(posedge clk); #1;
        bus.ifu_req = 1; bus.ifu_addr = 32'h200; bus.mem_stall = 1;
        seen_cen = 0; granted = 0;
        for (int c = 0; c < 10 && seen_cen == 0; c++) begin
            @(negedge clk);
            if (bus.ifu_gnt) granted = 1;
            if (bus.mem_c_en) seen_cen = 1;
            else begin
                @(posedge clk); #1;
                if (granted) clear_reqs();
            end
        end
        chk("midrst.c_en_before", 32'(seen_cen), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst.c_en_async_low", 32'(bus.mem_c_en), 32'd0);
        chk("midrst.busy_async_low", 32'(bus.busy), 32'd0);
        clear_reqs();
        bus.mem_stall = 0;
        @(negedge clk);
        resetn = 1'b1;
        rsp_cnt = 0; seen_cen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.ifu_rsp_valid || bus.lsu_rsp_valid) rsp_cnt++;
            if (bus.mem_c_en) seen_cen++;
        end
        chk("midrst.no_response", 32'(rsp_cnt), 32'd0);
        chk("midrst.no_c_en", 32'(seen_cen), 32'd0);

        // ---------------- random transactions vs model ----------------
        for (int i = 0; i < 200; i++) begin
            int r;
            v.is_lsu = ($urandom % 3) != 0;
            r = int'($urandom % 8);
            v.size   = v.is_lsu ? ((r < 7) ? 2'(r % 3) : 2'd3) : 2'd2;
            v.wen    = v.is_lsu ? 1'($urandom % 2) : 1'b0;
            v.sgn    = v.is_lsu ? 1'($urandom % 2) : 1'b0;
            v.addr   = $urandom;
            if (($urandom % 3) != 0) v.addr = v.addr & ~32'h1;
            if (($urandom % 2) != 0) v.addr = v.addr & ~32'h2;
            v.wdata  = $urandom;
            v.mrdata = $urandom;
            v.stalls = int'($urandom_range(0, 5));
            v.merr   = ($urandom % 8) == 0;
            run_txn(v, obs);
            compare($sformatf("rnd%0d", i), v, exp_of(v), obs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvm_mem_arbiter.md
Name: rvm_mem_arbiter

Overview:
- Shares the core's single memory port between two requesters: the fetch path (IFU, read-only word) and the load/store path (LSU, byte/half/word, read/write).
- Sequences each access with a state machine and steers byte lanes for sub-word accesses.
- Sign- or zero-extends load data, detects misalignment, and aborts accesses stalled beyond a timeout.
- Sits between rvm_control and the external mem_* pins of rvm_core.

Parameters:
- TIMEOUT_CYCLES, 255: stalled ACCESS cycles allowed before abort with error; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- ifu_req  in  1  fetch request
- ifu_addr  in  32  fetch byte address
- ifu_gnt  out  1  fetch request accepted this cycle
- ifu_rsp_valid  out  1  one-cycle fetch response strobe
- ifu_rdata  out  32  fetched word
- ifu_error  out  1  fetch failed (bus error, timeout or misalign)
- ifu_misalign  out  1  fetch address not word aligned
- lsu_req  in  1  data request
- lsu_wen  in  1  1 = store, 0 = load
- lsu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- lsu_signed  in  1  sign-extend load result
- lsu_addr  in  32  data byte address
- lsu_wdata  in  32  store data, right-aligned
- lsu_gnt  out  1  data request accepted this cycle
- lsu_rsp_valid  out  1  one-cycle data response strobe
- lsu_rdata  out  32  extended load data; 0 for stores
- lsu_error  out  1  data access failed
- lsu_misalign  out  1  data address misaligned for size, or size 11
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_rdata  in  32  memory read data
- mem_wdata  out  32  lane-replicated write data
- mem_c_en  out  1  memory chip enable
- mem_b_en  out  4  write byte strobes; 0000 = read
- mem_error  in  1  memory error, sampled on completion
- mem_stall  in  1  access not complete this cycle
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, all outputs 0, timeout counter 0, last_gnt = LSU, so the first tie goes to IFU. Async reset during ACCESS drops mem_c_en immediately; the pending response is lost.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Grant is combinational: a single requester wins; on a tie the requester not in last_gnt wins.
  - gnt is high for exactly that cycle. Request fields are registered at the edge, and last_gnt is updated. Requesters may drop req after gnt.
  - Aligned request -> ACCESS. Misaligned request -> RESP directly, with no memory access.
- ACCESS:
  - mem_c_en=1; mem_addr, mem_b_en and mem_wdata are driven from registers.
  - At an edge with mem_stall=0 the access completes: capture mem_rdata/mem_error -> RESP.
  - At an edge with mem_stall=1 the counter increments. If TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES, go RESP with error=1 (mem_c_en low from then on).
  - The counter clears on entry to ACCESS.
- RESP:
  - The granted side's rsp_valid=1 for one cycle with rdata/error/misalign -> IDLE.
  - No grant is issued in RESP. Minimum latency: gnt cycle 0, ACCESS cycle 1, rsp_valid cycle 2.
- Misalign rules:
  - IFU: addr[1:0]≠0.
  - LSU: half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - Response: error=1, misalign=1, rdata=0.
- Store lanes:
  - byte: b_en=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - half: b_en=addr[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - word: b_en=1111, wdata unchanged.
- Loads and fetches drive b_en=0000. Unused-side rdata and rsp outputs are 0.
- Load extract:
  - byte = mem_rdata[8*addr[1:0]+:8].
  - half = mem_rdata[16*addr[1]+:16].
  - Extend per lsu_signed.
- On error (bus or timeout), rdata=0. Store responses always carry rdata=0.
- Outside ACCESS: mem_c_en=0, mem_b_en=0; mem_addr/mem_wdata hold their last values.

Decomposition:
- Add to rvm_constants.v: state encodings, size encodings (RVM_MEM_BYTE/HALF/WORD), requester IDs.
- One combinational sub-module, rvm_mem_lanes: store lane steering, b_en generation, load extract/extend, misalign check. The FSM, counter and arbitration stay in rvm_mem_arbiter.

Test Plan:
- IFU read addr 0x100, mem_rdata 0xDEADBEEF, no stall -> ifu_gnt cycle 0, mem_c_en cycle 1 with mem_addr 0x100 and b_en 0000, ifu_rsp_valid cycle 2 with rdata 0xDEADBEEF.
- Simultaneous ifu_req and lsu_req straight after reset -> IFU granted first, LSU granted in the next IDLE; repeat the tie -> grants alternate.
- LSU signed byte load addr 0x203, mem_rdata 0x80112233 -> lsu_rdata 0xFFFFFF80; unsigned -> 0x00000080.
- LSU half store addr 0x402, wdata 0x0000ABCD -> mem_b_en 1100, mem_wdata 0xABCDABCD, mem_addr 0x400.
- LSU word load addr 0x6 -> no mem_c_en, lsu_rsp_valid one cycle after gnt with error=1, misalign=1, rdata 0.
- TIMEOUT_CYCLES=4, mem_stall held high -> after 4 stalled edges mem_c_en falls and rsp_valid shows error=1. Separately, 2 stall cycles then mem_error=1 -> error=1, rdata=0. Also assert resetn mid-ACCESS -> mem_c_en low asynchronously and no response.
